// File: rtl/systolic_pkg.sv
// Shared types, default widths and saturation bounds for the systolic GEMM/conv array.
package systolic_pkg;

  localparam int unsigned IN_WIDTH_DEF  = 16;
  localparam int unsigned OUT_WIDTH_DEF = 32;
  localparam int unsigned OUT_SCALE_DEF = 0;

  typedef logic signed [IN_WIDTH_DEF-1:0]  act_t;
  typedef logic signed [IN_WIDTH_DEF-1:0]  weight_t;
  typedef logic signed [OUT_WIDTH_DEF-1:0] psum_t;

  // Bounds of a width-bit two's-complement value, widened to 64 bits (width <= 64).
  function automatic logic signed [63:0] sat_max(input int unsigned width);
    sat_max = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned width);
    sat_min = -(64'sd1 <<< (width - 32'd1));
  endfunction

endpackage

// File: rtl/systolic_pe_if.sv
// Neighbour-facing bus of one processing element: west/north inputs, east/south outputs.
interface systolic_pe_if
  import systolic_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF
);

  logic signed [IN_WIDTH-1:0]  act_in;
  logic                        valid_in;
  logic signed [OUT_WIDTH-1:0] psum_in;
  logic signed [IN_WIDTH-1:0]  weight_in;
  logic                        weight_load;
  logic                        weight_swap;
  logic                        sat_clr;
  logic signed [IN_WIDTH-1:0]  act_out;
  logic                        valid_out;
  logic signed [IN_WIDTH-1:0]  weight_out;
  logic signed [OUT_WIDTH-1:0] psum_out;
  logic                        psum_valid;
  logic                        sat_flag;

  modport master (
    output act_in, valid_in, psum_in, weight_in, weight_load, weight_swap, sat_clr,
    input  act_out, valid_out, weight_out, psum_out, psum_valid, sat_flag
  );

  modport slave (
    input  act_in, valid_in, psum_in, weight_in, weight_load, weight_swap, sat_clr,
    output act_out, valid_out, weight_out, psum_out, psum_valid, sat_flag
  );

endinterface

// File: rtl/systolic_sat_add.sv
// Combinational signed adder with overflow detect; clamps only when SYSTOLIC_PE_SAT_EN is defined.
module systolic_sat_add
  import systolic_pkg::*;
#(
  parameter int unsigned WIDTH = OUT_WIDTH_DEF
) (
  input  logic signed [WIDTH-1:0] a_in,
  input  logic signed [WIDTH-1:0] b_in,
  output logic signed [WIDTH-1:0] sum_out,
  output logic                    ovf_out
);

  logic signed [WIDTH:0] sum_full_s;

`ifdef SYSTOLIC_PE_SAT_EN
  localparam logic signed [WIDTH-1:0] MAX_C = WIDTH'(sat_max(WIDTH));
  localparam logic signed [WIDTH-1:0] MIN_C = WIDTH'(sat_min(WIDTH));
`endif

  // One guard bit: overflow whenever the guard and the result sign disagree.
  always_comb begin
    sum_full_s = {a_in[WIDTH-1], a_in} + {b_in[WIDTH-1], b_in};
    ovf_out    = sum_full_s[WIDTH] ^ sum_full_s[WIDTH-1];
`ifdef SYSTOLIC_PE_SAT_EN
    if (ovf_out) begin
      sum_out = sum_full_s[WIDTH] ? MIN_C : MAX_C;
    end else begin
      sum_out = sum_full_s[WIDTH-1:0];
    end
`else
    sum_out = sum_full_s[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/systolic_pe.sv
// Weight-stationary systolic PE: double-buffered weight, two-stage valid-qualified MAC.
// Optional saturating accumulate with sticky flag: define SYSTOLIC_PE_SAT_EN.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int unsigned OUT_SCALE = OUT_SCALE_DEF
) (
  input logic          clk,
  input logic          arst_n_in,
  systolic_pe_if.slave bus
);

  typedef logic signed [IN_WIDTH-1:0]   in_t;
  typedef logic signed [OUT_WIDTH-1:0]  out_t;
  typedef logic signed [2*IN_WIDTH-1:0] prod_t;

  in_t   w_shadow_q, w_shadow_d;
  in_t   w_active_q, w_active_d;
  in_t   act_q, act_d;
  logic  valid_q, valid_d;
  out_t  prod_q, prod_d;
  out_t  psum_q, psum_d;
  logic  v1_q, v1_d;
  out_t  psum_out_q, psum_out_d;
  logic  psum_valid_q, psum_valid_d;
  logic  sat_flag_q, sat_flag_d;

  prod_t prod_full_s;
  prod_t prod_shift_s;
  out_t  add_sum_s;
  logic  add_ovf_s;

  systolic_sat_add #(.WIDTH(OUT_WIDTH)) u_add (
    .a_in    (psum_q),
    .b_in    (prod_q),
    .sum_out (add_sum_s),
    .ovf_out (add_ovf_s)
  );

`ifndef SYSTOLIC_PE_SAT_EN
  logic unused_s;
  assign unused_s = add_ovf_s ^ bus.sat_clr;
`endif

  // Next-state for weights, both pipeline stages, forwarding and the saturation flag.
  always_comb begin
    prod_full_s  = prod_t'(bus.act_in) * prod_t'(w_active_q);
    prod_shift_s = prod_full_s >>> OUT_SCALE;

    if (bus.weight_load) begin
      w_shadow_d = bus.weight_in;
    end else begin
      w_shadow_d = w_shadow_q;
    end
    // A swap always sees the pre-load shadow, so load+swap moves the old shadow.
    if (bus.weight_swap) begin
      w_active_d = w_shadow_q;
    end else begin
      w_active_d = w_active_q;
    end

    act_d   = bus.act_in;
    valid_d = bus.valid_in;

    v1_d = bus.valid_in;
    if (bus.valid_in) begin
      prod_d = out_t'(prod_shift_s);
      psum_d = bus.psum_in;
    end else begin
      prod_d = prod_q;
      psum_d = psum_q;
    end

    psum_valid_d = v1_q;
    if (v1_q) begin
      psum_out_d = add_sum_s;
    end else begin
      psum_out_d = psum_out_q;
    end

`ifdef SYSTOLIC_PE_SAT_EN
    // A clamp in the same cycle as a clear wins.
    if (v1_q && add_ovf_s) begin
      sat_flag_d = 1'b1;
    end else if (bus.sat_clr) begin
      sat_flag_d = 1'b0;
    end else begin
      sat_flag_d = sat_flag_q;
    end
`else
    sat_flag_d = 1'b0;
`endif
  end

  // State registers; everything clears on reset so in-flight samples are dropped.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      w_shadow_q   <= '0;
      w_active_q   <= '0;
      act_q        <= '0;
      valid_q      <= 1'b0;
      prod_q       <= '0;
      psum_q       <= '0;
      v1_q         <= 1'b0;
      psum_out_q   <= '0;
      psum_valid_q <= 1'b0;
      sat_flag_q   <= 1'b0;
    end else begin
      w_shadow_q   <= w_shadow_d;
      w_active_q   <= w_active_d;
      act_q        <= act_d;
      valid_q      <= valid_d;
      prod_q       <= prod_d;
      psum_q       <= psum_d;
      v1_q         <= v1_d;
      psum_out_q   <= psum_out_d;
      psum_valid_q <= psum_valid_d;
      sat_flag_q   <= sat_flag_d;
    end
  end

  assign bus.act_out    = act_q;
  assign bus.valid_out  = valid_q;
  assign bus.weight_out = w_shadow_q;
  assign bus.psum_out   = psum_out_q;
  assign bus.psum_valid = psum_valid_q;
  assign bus.sat_flag   = sat_flag_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Directed bench for systolic_pe: vector table plus hand sequences for swap, scale, stream, reset.
module tb_systolic_pe;

  localparam int unsigned IW = 8;
  localparam int unsigned OW = 16;
`ifdef SYSTOLIC_PE_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  systolic_pe_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) if0 ();
  systolic_pe_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) if4 ();

  systolic_pe #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .OUT_SCALE(0)) dut0 (
    .clk(clk), .arst_n_in(rst_n), .bus(if0.slave));
  systolic_pe #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .OUT_SCALE(4)) dut4 (
    .clk(clk), .arst_n_in(rst_n), .bus(if4.slave));

  typedef struct {
    logic signed [IW-1:0] w;
    logic signed [IW-1:0] act;
    logic signed [OW-1:0] psum;
    logic signed [OW-1:0] exp_psum;
    logic                 exp_sat;
  } vec_t;

  vec_t vecs [5];
  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] vpat = 11'b110_1111_1111;
  logic signed [OW-1:0] model;
  logic pv;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if0.act_in = '0; if0.valid_in = 1'b0; if0.psum_in = '0; if0.weight_in = '0;
    if0.weight_load = 1'b0; if0.weight_swap = 1'b0; if0.sat_clr = 1'b0;
    if4.act_in = '0; if4.valid_in = 1'b0; if4.psum_in = '0; if4.weight_in = '0;
    if4.weight_load = 1'b0; if4.weight_swap = 1'b0; if4.sat_clr = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_act_out"},    if0.act_out,    32'sd0);
    chk({tag, "_valid_out"},  if0.valid_out,  32'sd0);
    chk({tag, "_weight_out"}, if0.weight_out, 32'sd0);
    chk({tag, "_psum_out"},   if0.psum_out,   32'sd0);
    chk({tag, "_psum_valid"}, if0.psum_valid, 32'sd0);
    chk({tag, "_sat_flag"},   if0.sat_flag,   32'sd0);
    chk({tag, "_psum_out4"},  if4.psum_out,   32'sd0);
  endtask

  initial begin
    vecs[0] = '{w: 8'sd3,    act: 8'sd5,    psum: 16'sd10,     exp_psum: 16'sd25,    exp_sat: 1'b0};
    vecs[1] = '{w: -8'sd4,   act: 8'sd7,    psum: 16'sd100,    exp_psum: 16'sd72,    exp_sat: 1'b0};
    vecs[2] = '{w: 8'sh80,   act: 8'sh80,   psum: 16'sd0,      exp_psum: 16'sd16384, exp_sat: 1'b0};
    vecs[3] = '{w: 8'sd127,  act: 8'sd127,  psum: 16'sd30000,
                exp_psum: SAT_EN ? 16'sd32767 : -16'sd19407, exp_sat: SAT_EN};
    vecs[4] = '{w: 8'sh80,   act: 8'sd127,  psum: -16'sd20000,
                exp_psum: SAT_EN ? 16'sh8000 : 16'sd29280,   exp_sat: SAT_EN};

    rst_n = 1'b0;
    idle();
    #12;
    chk_zero("reset");
    #5 rst_n = 1'b1;
    step();

    // Table: load, swap, one sample, then observe forwarding, result and sticky flag.
    for (int i = 0; i < 5; i++) begin
      if0.weight_in = vecs[i].w; if0.weight_load = 1'b1;
      step();
      chk("vec_weight_out", if0.weight_out, vecs[i].w);
      if0.weight_load = 1'b0; if0.weight_swap = 1'b1;
      step();
      if0.weight_swap = 1'b0; if0.valid_in = 1'b1;
      if0.act_in = vecs[i].act; if0.psum_in = vecs[i].psum;
      step();
      chk("vec_act_out", if0.act_out, vecs[i].act);
      chk("vec_valid_out", if0.valid_out, 32'sd1);
      if0.valid_in = 1'b0;
      step();
      chk("vec_psum_out", if0.psum_out, vecs[i].exp_psum);
      chk("vec_psum_valid", if0.psum_valid, 32'sd1);
      chk("vec_sat_flag", if0.sat_flag, vecs[i].exp_sat);
      step();
      chk("vec_sat_sticky", if0.sat_flag, vecs[i].exp_sat);
      chk("vec_psum_hold", if0.psum_out, vecs[i].exp_psum);
      chk("vec_psum_valid_drop", if0.psum_valid, 32'sd0);
      if0.sat_clr = 1'b1;
      step();
      if0.sat_clr = 1'b0;
      chk("vec_sat_cleared", if0.sat_flag, 32'sd0);
    end

    // Swap coincident with a valid sample: that sample still uses the old weight.
    if0.weight_in = 8'sd3; if0.weight_load = 1'b1; step();
    if0.weight_load = 1'b0; if0.weight_swap = 1'b1; step();
    if0.weight_swap = 1'b0; if0.weight_in = 8'sd2; if0.weight_load = 1'b1; step();
    chk("swap_shadow", if0.weight_out, 32'sd2);
    if0.weight_load = 1'b0; if0.weight_swap = 1'b1;
    if0.valid_in = 1'b1; if0.act_in = 8'sd4; if0.psum_in = 16'sd1; step();
    if0.weight_swap = 1'b0; step();
    chk("swap_old_weight", if0.psum_out, 32'sd13);
    if0.valid_in = 1'b0; step();
    chk("swap_new_weight", if0.psum_out, 32'sd9);
    chk("swap_new_valid", if0.psum_valid, 32'sd1);

    // Load and swap together: active takes the old shadow, shadow takes the new weight.
    if0.weight_in = 8'sd6; if0.weight_load = 1'b1; step();
    if0.weight_in = 8'sd5; if0.weight_swap = 1'b1; step();
    chk("loadswap_shadow", if0.weight_out, 32'sd5);
    if0.weight_load = 1'b0; if0.weight_swap = 1'b0;
    if0.valid_in = 1'b1; if0.act_in = 8'sd1; if0.psum_in = 16'sd0; step();
    if0.valid_in = 1'b0; step();
    chk("loadswap_active", if0.psum_out, 32'sd6);

    // Clamp and clear land on the same edge: the clamp wins.
    if0.weight_in = 8'sd127; if0.weight_load = 1'b1; step();
    if0.weight_load = 1'b0; if0.weight_swap = 1'b1; step();
    if0.weight_swap = 1'b0; if0.valid_in = 1'b1;
    if0.act_in = 8'sd127; if0.psum_in = 16'sd30000; step();
    if0.valid_in = 1'b0; if0.sat_clr = 1'b1; step();
    chk("clrclamp_psum", if0.psum_out, SAT_EN ? 32'sd32767 : -32'sd19407);
    chk("clrclamp_flag", if0.sat_flag, SAT_EN);
    step();
    if0.sat_clr = 1'b0;
    chk("clrclamp_cleared", if0.sat_flag, 32'sd0);

    // Scaled PE: arithmetic right shift by 4 rounds toward minus infinity.
    if4.weight_in = -8'sd8; if4.weight_load = 1'b1; step();
    if4.weight_load = 1'b0; if4.weight_swap = 1'b1; step();
    if4.weight_swap = 1'b0; if4.valid_in = 1'b1;
    if4.act_in = 8'sd16; if4.psum_in = 16'sd0; step();
    if4.act_in = 8'sd1; if4.psum_in = 16'sd100; step();
    if4.valid_in = 1'b0;
    chk("scale_neg8", if4.psum_out, -32'sd8);
    step();
    chk("scale_floor", if4.psum_out, 32'sd99);

    // Stream of 8 valids, a bubble, then 2 more against a reference model.
    if0.weight_in = -8'sd3; if0.weight_load = 1'b1; step();
    if0.weight_load = 1'b0; if0.weight_swap = 1'b1; step();
    if0.weight_swap = 1'b0;
    model = '0;
    for (int c = 0; c < 12; c++) begin
      if (c < 11) begin
        if0.valid_in = vpat[c];
        if0.act_in   = IW'(c * 9 - 40);
        if0.psum_in  = OW'(c * 1500 - 7000);
      end else begin
        if0.valid_in = 1'b0;
      end
      step();
      if (c < 11) chk("stream_valid_out", if0.valid_out, vpat[c]);
      if (c >= 1) begin
        pv = vpat[c-1];
        chk("stream_psum_valid", if0.psum_valid, pv);
        if (pv) model = OW'(((c - 1) * 1500 - 7000) + ((c - 1) * 9 - 40) * -3);
        chk("stream_psum", if0.psum_out, model);
      end
    end

    // Reset with samples in flight: everything clears, no stale valid afterwards.
    if0.valid_in = 1'b1; if0.act_in = 8'sd10; if0.psum_in = 16'sd5; step();
    if0.act_in = 8'sd11; step();
    if0.act_in = 8'sd12;
    #2 rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    idle();
    step();
    chk_zero("midrst_hold");
    #3 rst_n = 1'b1;
    step();
    chk("postrst_psum_valid", if0.psum_valid, 32'sd0);
    chk("postrst_valid_out", if0.valid_out, 32'sd0);
    if0.valid_in = 1'b1; if0.act_in = 8'sd9; if0.psum_in = 16'sd7; step();
    if0.valid_in = 1'b0;
    chk("postrst_idle_valid", if0.psum_valid, 32'sd0);
    step();
    chk("postrst_zero_weight", if0.psum_out, 32'sd7);
    chk("postrst_new_valid", if0.psum_valid, 32'sd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_pe.md
# systolic_pe

Parametrised weight-stationary processing element for the systolic GEMM/conv array. Generalises the single-width combinational-add MAC cell:
- separate input and accumulator widths
- signed fixed-point rescaling
- double-buffered weight with daisy-chain loading
- valid-qualified two-stage pipeline with activation forwarding
- optional saturating accumulate

Tiles into an R×C grid. Activations and valids flow east, partial sums flow south, weights shift south through the shadow chain.

## Interface
- IN_WIDTH, 16: signed width of activation and weight.
- OUT_WIDTH, 32: signed width of partial sums; must be ≥ IN_WIDTH.
- OUT_SCALE, 0: arithmetic right shift applied to the product before accumulation; range 0..2*IN_WIDTH-1.

Ports:
- clk  in  1  clock, all state on rising edge.
- arst_n_in  in  1  asynchronous reset, active low.
- act_in  in  IN_WIDTH  activation from west neighbour.
- valid_in  in  1  act_in/psum_in qualifier.
- psum_in  in  OUT_WIDTH  partial sum from north neighbour.
- weight_in  in  IN_WIDTH  weight from north neighbour (load chain).
- weight_load  in  1  shift weight_in into shadow register.
- weight_swap  in  1  copy shadow weight into active weight.
- act_out  out  IN_WIDTH  registered act_in to east.
- valid_out  out  1  registered valid_in to east.
- weight_out  out  IN_WIDTH  shadow weight to south.
- psum_out  out  OUT_WIDTH  accumulated partial sum to south.
- psum_valid  out  1  psum_out qualifier.
- sat_flag  out  1  sticky saturation indicator (see Configuration).
- sat_clr  in  1  clears sat_flag.

## Operation
- Weight registers:
  - w_shadow loads weight_in when weight_load=1.
  - w_active loads w_shadow when weight_swap=1.
  - Load and swap in the same cycle: w_active takes the old w_shadow; w_shadow takes weight_in.
  - weight_out = w_shadow, so asserting weight_load on a whole column for R cycles shifts R weights down the column.
- Stage 1, when valid_in=1:
  - prod_q = (act_in × w_active) as full 2*IN_WIDTH signed product, arithmetically shifted right by OUT_SCALE, then sign-extended or truncated to OUT_WIDTH.
  - psum_q = psum_in.
  - v1 = valid_in, every cycle.
- Stage 2, when v1=1: psum_out = psum_q + prod_q (OUT_WIDTH signed, wrap or saturate per Configuration). psum_valid = v1 every cycle.
- Data registers (prod_q, psum_q, psum_out) hold when their stage valid is 0. Only valid bits and sat_flag are reset-critical for data.
- act_out/valid_out: registered copies of act_in/valid_in every cycle, regardless of weight activity.
- The active weight used is the value of w_active in the cycle valid_in is sampled. A swap in cycle t affects samples accepted from cycle t+1. No stall or backpressure; the array never stalls.

## Timing
- act_out/valid_out latency: 1 cycle.
- psum_out/psum_valid latency: 2 cycles from valid_in. The array feeder skews successive rows by 2 cycles relative to the psum wavefront.
- weight_out: 1 cycle after weight_load.
- Reset values, all outputs and internal registers: 0. This includes w_shadow, w_active, v1 and sat_flag.
- Reset mid-operation: in-flight samples are discarded; psum_valid=0 the cycle after reset deasserts.
- Back-to-back valid_in: one result per cycle, no bubbles.

## Configuration
- SYSTOLIC_PE_SAT_EN defined:
  - Stage-2 add saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Any clamp sets sat_flag, which stays set until sat_clr=1 or reset.
  - sat_clr and a new clamp in the same cycle: sat_flag stays 1.
- Undefined:
  - Two's-complement wrap.
  - sat_flag tied to 0; sat_clr ignored.

## Structure
- Shared package systolic_pkg:
  - act_t/weight_t (logic signed [IN_WIDTH-1:0]) and psum_t typedef templates.
  - Default width localparams.
  - Saturation min/max constant functions.
- One sub-module, systolic_sat_add: combinational OUT_WIDTH signed adder with overflow detect and macro-selected clamp. Reused by the array's edge accumulators.

## Test plan
- IN=8, OUT=16, SCALE=0:
  - Load w=3 then swap; act=5, psum_in=10, valid=1 → psum_out=25, psum_valid=1 exactly 2 cycles later; act_out=5 after 1 cycle.
  - Load w=2 while w_active=3, swap in the same cycle as a valid act=4 → that result uses 3 (12+psum_in); the next sample uses 2.
  - w=127, act=127, psum_in=30000:
    - with SYSTOLIC_PE_SAT_EN → 32767 and sat_flag=1 until sat_clr.
    - without → -19407 and sat_flag=0.
- IN=8, OUT=16, SCALE=4: w=-8, act=16, psum_in=0 → psum_out=-8 (arithmetic shift).
- Stream 8 consecutive valids, then 1 bubble, then 2 → psum_valid pattern identical, delayed 2 cycles; data matches a reference model.
- Assert arst_n_in low with 2 samples in flight → all outputs 0, including weights; no stale psum_valid after release.
